pll_lock_supervisor: RTL and testbench

Supervises the iCE40 PLL from the 12 MHz reference-clock side: drives the PLL's active-low RESETB, consumes its raw LOCK output, and produces a clean, debounced active-low reset for logic running on the 249 MHz PLL output. It retries PLL lock on timeout, enters a sticky fault after repeated failures, and counts loss-of-lock events for status readout. It sits between the board oscillator input and the PLL instance at the top level.

---
 rtl/pll_lock_supervisor.sv | 88 ++++++++
 tb/tb_pll_lock_supervisor.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences iCE40 PLL reset, qualifies lock and issues a clean reset for the PLL clock domain.
module pll_lock_supervisor #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 12000,
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);
  localparam int SW = LOCK_STABLE_CYCLES > 1 ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int TW = LOCK_TIMEOUT_CYCLES > 1 ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int PW = PLL_RESET_CYCLES > 1 ? $clog2(PLL_RESET_CYCLES) : 1;
  localparam int RW = MAX_RETRIES > 1 ? $clog2(MAX_RETRIES) : 1;
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] RST_LAST = PW'(PLL_RESET_CYCLES - 1);
  localparam logic [RW-1:0] RTY_LAST = RW'(MAX_RETRIES - 1);
  localparam logic [2:0] S_PLL_RST = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_STABLE  = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;
  logic          r_sync, r_lock_s;
  logic [2:0]    r_state, w_next;
  logic [SW-1:0] r_stb_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [PW-1:0] r_rst_cnt;
  logic [RW-1:0] r_retry;
  logic [7:0]    r_loss;
  logic          r_pll_resetb, r_sys_reset_n, r_ready, r_fault;
  logic          w_timeout;
  assign w_timeout = r_to_cnt == TO_LAST;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_PLL_RST: w_next = r_rst_cnt == RST_LAST ? S_WAIT : S_PLL_RST;
      S_WAIT:    w_next = r_lock_s ? S_STABLE : !w_timeout ? S_WAIT : r_retry == RTY_LAST ? S_FAULT : S_PLL_RST;
      S_STABLE:  w_next = !r_lock_s ? S_WAIT : r_stb_cnt >= STB_LAST ? S_RUN : S_STABLE;
      S_RUN:     w_next = r_lock_s ? S_RUN : S_WAIT;
      S_FAULT:   w_next = S_FAULT;
      default:   w_next = S_PLL_RST;
    endcase
  end
  // STABLE entry already consumed one high lock_s sample, so the qualifier starts at 1
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync        <= 1'b0;
      r_lock_s      <= 1'b0;
      r_state       <= S_PLL_RST;
      r_stb_cnt     <= '0;
      r_to_cnt      <= '0;
      r_rst_cnt     <= '0;
      r_retry       <= '0;
      r_loss        <= '0;
      r_pll_resetb  <= 1'b0;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_sync        <= pll_locked;
      r_lock_s      <= r_sync;
      r_state       <= w_next;
      r_rst_cnt     <= (r_state == S_PLL_RST && w_next == S_PLL_RST) ? r_rst_cnt + 1'b1 : '0;
      r_to_cnt      <= (r_state == S_WAIT && w_next == S_WAIT) ? r_to_cnt + 1'b1 : '0;
      r_stb_cnt     <= w_next != S_STABLE ? '0 : r_state == S_STABLE ? r_stb_cnt + 1'b1 : SW'(1);
      r_retry       <= w_next == S_RUN ? '0 : (r_state == S_WAIT && w_next == S_PLL_RST) ? r_retry + 1'b1 : r_retry;
      r_loss        <= (r_state == S_RUN && w_next == S_WAIT && r_loss != 8'hff) ? r_loss + 1'b1 : r_loss;
      r_pll_resetb  <= !(w_next == S_PLL_RST || w_next == S_FAULT);
      r_sys_reset_n <= w_next == S_RUN;
      r_ready       <= w_next == S_RUN;
      r_fault       <= w_next == S_FAULT;
    end
  end
  assign pll_resetb      = r_pll_resetb;
  assign sys_reset_n     = r_sys_reset_n;
  assign ready           = r_ready;
  assign fault           = r_fault;
  assign lock_loss_count = r_loss;
  assign state           = r_state;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scoreboard bench; expectations are queued with a target edge and checked when that edge has passed.
module tb_pll_lock_supervisor;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_resetb, sys_reset_n, ready, fault;
  logic [7:0] lock_loss_count;
  logic [2:0] state;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  typedef struct { int cyc; int sel; int val; } exp_t;
  exp_t sb[$];
  pll_lock_supervisor #(
    .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32), .PLL_RESET_CYCLES(4), .MAX_RETRIES(2)
  ) dut (
    .clock_in(clk), .reset_n(reset_n), .pll_locked(pll_locked), .pll_resetb(pll_resetb),
    .sys_reset_n(sys_reset_n), .ready(ready), .fault(fault),
    .lock_loss_count(lock_loss_count), .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, cyc);
  endtask
  function automatic logic [31:0] obs(input int sel);
    return sel == 0 ? 32'(state) : sel == 1 ? 32'(pll_resetb) : sel == 2 ? 32'(sys_reset_n) :
           sel == 3 ? 32'(ready) : sel == 4 ? 32'(fault) : 32'(lock_loss_count);
  endfunction
  function automatic string name(input int sel);
    return sel == 0 ? "state" : sel == 1 ? "pll_resetb" : sel == 2 ? "sys_reset_n" :
           sel == 3 ? "ready" : sel == 4 ? "fault" : "lock_loss_count";
  endfunction
  task automatic push(input int dly, input int sel, input int val);
    sb.push_back('{cyc + dly, sel, val});
  endtask
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc == cyc) begin
        chk(name(sb[i].sel), obs(sb[i].sel), 32'(sb[i].val));
        sb.delete(i);
      end
  end
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"}, 32'(state), 0);
    chk({pfx, "_pll_resetb"}, 32'(pll_resetb), 0);
    chk({pfx, "_sys_reset_n"}, 32'(sys_reset_n), 0);
    chk({pfx, "_ready"}, 32'(ready), 0);
    chk({pfx, "_fault"}, 32'(fault), 0);
    chk({pfx, "_count"}, 32'(lock_loss_count), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
  initial begin
    // nominal bring-up
    do_reset();
    chk_reset_vals("rst");
    push(3, 1, 0); push(4, 1, 1); push(4, 0, 1);
    repeat (10) @(negedge clk);
    pll_locked = 1'b1;
    push(2, 0, 1); push(3, 0, 2); push(9, 2, 0); push(10, 2, 1); push(10, 3, 1); push(10, 0, 3);
    repeat (12) @(negedge clk);
    // lock bounce at stable count 5
    pll_locked = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);
    pll_locked = 1'b1;
    repeat (7) @(negedge clk);
    pll_locked = 1'b0;
    push(2, 0, 2); push(3, 0, 1); push(4, 0, 1); push(5, 0, 2);
    push(11, 0, 2); push(11, 3, 0); push(12, 0, 3); push(12, 3, 1); push(12, 5, 0);
    repeat (2) @(negedge clk);
    pll_locked = 1'b1;
    repeat (11) @(negedge clk);
    // loss of lock in RUN
    pll_locked = 1'b0;
    push(2, 2, 1); push(3, 2, 0); push(3, 0, 1); push(3, 5, 1); push(3, 1, 1);
    push(8, 1, 1); push(12, 2, 0); push(13, 2, 1); push(13, 0, 3); push(13, 5, 1);
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    repeat (12) @(negedge clk);
    // timeout, retry, then sticky fault
    pll_locked = 1'b0;
    push(34, 0, 1); push(34, 1, 1); push(35, 0, 0); push(35, 1, 0); push(38, 1, 0);
    push(39, 1, 1); push(39, 0, 1); push(70, 0, 1); push(71, 0, 4); push(71, 4, 1);
    push(71, 1, 0); push(71, 2, 0);
    repeat (75) @(negedge clk);
    pll_locked = 1'b1;
    push(5, 0, 4); push(5, 4, 1); push(5, 1, 0);
    repeat (6) @(negedge clk);
    // loss counter saturation
    pll_locked = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);
    pll_locked = 1'b1;
    repeat (12) @(negedge clk);
    chk("run_before_losses", 32'(state), 3);
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      push(3, 5, i + 1 > 255 ? 255 : i + 1);
      push(11, 0, 3);
      @(negedge clk);
      pll_locked = 1'b1;
      repeat (11) @(negedge clk);
    end
    chk("count_saturated", 32'(lock_loss_count), 255);
    // asynchronous reset between edges
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("sb_pending", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
